// File: rtl/pad_pwm_pkg.sv
// Shared types for the pad PWM driver: FSM state encoding and the configuration
// record that moves from the handshake into the shadow and active registers.
package pad_pwm_pkg;

  localparam int PWM_CNT_W  = 16;
  localparam int PWM_ATTR_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  typedef struct packed {
    logic                  en;
    logic                  pol;
    logic [PWM_CNT_W-1:0]  period;
    logic [PWM_CNT_W-1:0]  duty;
    logic [PWM_ATTR_W-1:0] attr;
  } pwm_cfg_t;

  // A configuration keeps the output running only if it is enabled and its
  // period is non-zero; anything else parks the pad in its idle level.
  function automatic logic cfg_runs(input pwm_cfg_t cfg);
    return cfg.en && (cfg.period != '0);
  endfunction

endpackage

// File: rtl/pad_pwm_if.sv
// Configuration handshake and pad-side signal bundle of the PWM driver.
// master = the configuring agent, slave = the driver.
interface pad_pwm_if
  import pad_pwm_pkg::*;
#(
  parameter int CNT_W   = PWM_CNT_W,
  parameter int PADATTR = PWM_ATTR_W
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_en;
  logic               cfg_pol;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_duty;
  logic [PADATTR-1:0] cfg_attr;

  logic               pad_out;
  logic               pad_oe;
  logic [PADATTR-1:0] pad_attributes;
  logic               period_done;

  modport master (
    output cfg_valid, cfg_en, cfg_pol, cfg_period, cfg_duty, cfg_attr,
    input  cfg_ready, pad_out, pad_oe, pad_attributes, period_done
  );

  modport slave (
    input  cfg_valid, cfg_en, cfg_pol, cfg_period, cfg_duty, cfg_attr,
    output cfg_ready, pad_out, pad_oe, pad_attributes, period_done
  );

endinterface

// File: rtl/pad_pwm_counter.sv
// Period counter with wrap detection and duty compare. The counter sits at zero
// whenever the driver is not running, so entering RUN always starts a fresh period.
module pad_pwm_counter
  import pad_pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             wrap_o,
  output logic             raw_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  // period_i is never zero while running, so period-1 cannot underflow there.
  assign at_last = (cnt_q == (period_i - CNT_W'(1)));
  assign wrap_o  = run_i && at_last;

  // Unsigned compare: duty 0 never matches, duty >= period always matches.
  assign raw_o = (cnt_q < duty_i);

  always_comb begin
    cnt_d = '0;
    if (run_i && !at_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pad_pwm_driver.sv
// PWM pad driver: one-deep shadow configuration, applied immediately from IDLE
// or only at a period wrap while running, with a registered pad output stage.
module pad_pwm_driver
  import pad_pwm_pkg::*;
#(
  parameter int CNT_W   = PWM_CNT_W,
  parameter int PADATTR = PWM_ATTR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic               cfg_en_i,
  input  logic               cfg_pol_i,
  input  logic [CNT_W-1:0]   cfg_period_i,
  input  logic [CNT_W-1:0]   cfg_duty_i,
  input  logic [PADATTR-1:0] cfg_attr_i,
  output logic               pad_out_o,
  output logic               pad_oe_o,
  output logic [PADATTR-1:0] pad_attributes_o,
  output logic               period_done_o
);

  pwm_state_e state_q;
  pwm_state_e state_d;
  pwm_cfg_t   shadow_q;
  pwm_cfg_t   shadow_d;
  logic       pending_q;
  logic       pending_d;
  pwm_cfg_t   active_q;
  pwm_cfg_t   active_d;
  logic       pad_out_q;
  logic       pad_out_d;
  logic       pad_oe_q;
  logic       pad_oe_d;

  pwm_cfg_t   cfg_in;
  logic       running;
  logic       accept;
  logic       apply;
  logic       wrap;
  logic       raw;

  always_comb begin
    cfg_in        = '0;
    cfg_in.en     = cfg_en_i;
    cfg_in.pol    = cfg_pol_i;
    cfg_in.period = PWM_CNT_W'(cfg_period_i);
    cfg_in.duty   = PWM_CNT_W'(cfg_duty_i);
    cfg_in.attr   = PWM_ATTR_W'(cfg_attr_i);
  end

  assign running     = (state_q == ST_RUN);
  assign cfg_ready_o = !pending_q;
  assign accept      = cfg_valid_i && !pending_q;
  // A config accepted on a wrap cycle is only pending from the next cycle on,
  // so it waits for the following wrap rather than cutting the new period.
  assign apply       = pending_q && (!running || wrap);

  pad_pwm_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (running),
    .period_i (CNT_W'(active_q.period)),
    .duty_i   (CNT_W'(active_q.duty)),
    .wrap_o   (wrap),
    .raw_o    (raw)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    active_d  = active_q;

    if (accept) begin
      shadow_d  = cfg_in;
      pending_d = 1'b1;
    end

    if (apply) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      state_d   = cfg_runs(shadow_q) ? ST_RUN : ST_IDLE;
    end
  end

  // Pin stage lags the counter by one cycle; idle level is the active polarity.
  always_comb begin
    pad_out_d = active_q.pol;
    pad_oe_d  = 1'b0;
    if (running) begin
      pad_out_d = raw ^ active_q.pol;
      pad_oe_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      active_q  <= '0;
      pad_out_q <= 1'b0;
      pad_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
    end
  end

  assign pad_out_o        = pad_out_q;
  assign pad_oe_o         = pad_oe_q;
  assign pad_attributes_o = PADATTR'(active_q.attr);
  assign period_done_o    = wrap;

endmodule

// File: doc/pad_pwm_driver.md
PAD_PWM_DRIVER -- requirements
Module: pad_pwm_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 16, counter/period/duty width.
REQ-002 SHALL have parameter PADATTR, default 16, pad attribute width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid_i  input  1  new configuration offered.
REQ-006 SHALL have port cfg_ready_o  output  1  configuration can be accepted.
REQ-007 SHALL have port cfg_en_i  input  1  requested run enable.
REQ-008 SHALL have port cfg_pol_i  input  1  output polarity; 1 inverts the waveform and idle level.
REQ-009 SHALL have port cfg_period_i  input  CNT_W  period in cycles.
REQ-010 SHALL have port cfg_duty_i  input  CNT_W  high-time in cycles.
REQ-011 SHALL have port cfg_attr_i  input  PADATTR  pad attributes to apply.
REQ-012 SHALL have port pad_out_o  output  1  value to the output pad cell data input.
REQ-013 SHALL have port pad_oe_o  output  1  output enable to the output pad cell.
REQ-014 SHALL have port pad_attributes_o  output  PADATTR  registered attributes to the pad cell.
REQ-015 SHALL have port period_done_o  output  1  one-cycle pulse at every period wrap.

Function
REQ-016 SHALL accept a configuration on cycles where cfg_valid_i and cfg_ready_o are both 1 and hold it in a single pending (shadow) register.
REQ-017 cfg_ready_o SHALL be 1 exactly when no configuration is pending.
REQ-018 SHALL implement states IDLE and RUN.
REQ-019 In IDLE, a pending configuration SHALL be applied in the cycle after acceptance; if cfg_en_i=1 and period!=0, the FSM SHALL enter RUN with counter=0.
REQ-020 In RUN, the counter SHALL increment each cycle and wrap to 0 after reaching period-1; period_done_o SHALL pulse in the cycle the counter equals period-1.
REQ-021 In RUN, a pending configuration SHALL be applied only at the wrap cycle, so no period is truncated.
REQ-022 On a wrap cycle, an applied configuration with en=0 or period=0 SHALL move the FSM to IDLE.
REQ-023 If acceptance coincides with a wrap cycle, the new configuration SHALL take effect at the next wrap, not the current one.
REQ-024 In RUN, raw waveform SHALL be 1 when counter < duty, else 0; duty=0 SHALL give constant 0, and duty>=period SHALL give constant 1.
REQ-025 pad_out_o SHALL equal raw XOR pol and SHALL be registered, with one cycle latency from counter to pin.
REQ-026 In IDLE, pad_out_o SHALL be pol and pad_oe_o SHALL be 0.
REQ-027 In RUN, pad_oe_o SHALL be 1.
REQ-028 pad_attributes_o SHALL update when a configuration is applied, never mid-period.
REQ-029 Counter comparisons SHALL be unsigned CNT_W-bit, with no overflow beyond period-1.

Reset
REQ-030 On rst_i=1, the FSM SHALL go to IDLE, clear counter and pending, and drive pad_out_o=0, pad_oe_o=0, pad_attributes_o=0, period_done_o=0 and cfg_ready_o=1 in the following cycle.
REQ-031 Reset asserted in RUN SHALL abort the period immediately and discard any pending configuration.

Structure
REQ-032 Package pad_pwm_pkg SHALL hold the state enum and the configuration struct type {en, pol, period, duty, attr}.
REQ-033 A sub-module pad_pwm_counter (counter, wrap detection, compare) is natural; the FSM and shadow logic SHALL stay at top level.

Verification
REQ-034 Config period=4, duty=1, en=1, pol=0 from IDLE -> pad_oe_o=1 and pad_out_o pattern 1000 repeating; period_done_o pulses every 4 cycles.
REQ-035 While running period=4/duty=1, accept period=6/duty=3 mid-period -> current period completes as 1000, then 111000; cfg_ready_o is 0 until the wrap.
REQ-036 Edge duties with period=5: duty=0 -> constant 0; duty=5 -> constant 1; duty=9 -> constant 1.
REQ-037 pol=1, period=4, duty=1 -> pattern 0111; after en=0 is applied at the wrap -> pad_oe_o=0 and pad_out_o=1.
REQ-038 Assert rst_i for one cycle while running with a config pending -> next cycle all outputs are at reset values, cfg_ready_o=1, and no pulse is produced.
REQ-039 Hold cfg_valid_i high during a wrap with back-to-back configurations -> exactly one configuration is accepted per wrap and none is lost or applied early.
